// File: rtl/mips_pkg.sv
// Shared constants and state type for the multi-cycle core's multiply/divide sequencer.
package mips_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_STEPS = MULDIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand/result bundle between control_unit (master) and the muldiv engine (slave).
interface muldiv_sequencer_if
    import mips_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);

    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start_mult, start_div, op_a, op_b,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b,
        output busy, done, div_zero, hi_out, lo_out
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and result sign restoration around the unsigned iteration.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [2*WIDTH:0]   acc,
    input  logic               is_mult,
    input  logic               sign_a,
    input  logic               sign_b,
    output logic [WIDTH:0]     mag_a,
    output logic [WIDTH:0]     mag_b,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               unused_acc_msb;

    // One extra bit so the magnitude of the most negative operand is representable.
    assign ext_a = {op_a[WIDTH-1], op_a};
    assign ext_b = {op_b[WIDTH-1], op_b};
    assign mag_a = op_a[WIDTH-1] ? -ext_a : ext_a;
    assign mag_b = op_b[WIDTH-1] ? -ext_b : ext_b;

    assign prod = (sign_a ^ sign_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign quot = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign res_hi = is_mult ? prod[2*WIDTH-1:WIDTH] : rem;
    assign res_lo = is_mult ? prod[WIDTH-1:0] : quot;

    assign unused_acc_msb = acc[2*WIDTH];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine: one shift-add or restoring-subtract step per cycle.
//  state | meaning
//  IDLE  | waiting for start_mult/start_div; operands captured here
//  MULT  | shift-add iterations, counter 0..WIDTH-1
//  DIV   | restoring-divide iterations, counter 0..WIDTH-1
//  DONE  | one-cycle done pulse, div_zero when divisor was zero
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);

    localparam int STEPS = WIDTH;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   acc_q, acc_step;
    logic [WIDTH:0]     opnd_q;
    logic               sign_a_q, sign_b_q, is_mult_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH:0]     mag_a, mag_b;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH:0]   div_shift;

    // Results are derived from the step about to be registered so they land on DONE entry.
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_a    (bus.op_a),
        .op_b    (bus.op_b),
        .acc     (acc_step),
        .is_mult (is_mult_q),
        .sign_a  (sign_a_q),
        .sign_b  (sign_b_q),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .res_hi  (res_hi),
        .res_lo  (res_lo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_mult)
                    state_d = MULT;
                else if (bus.start_div)
                    state_d = (bus.op_b == '0) ? DONE : DIV;
            end
            MULT, DIV: if (cnt_q == LAST) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mult_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? opnd_q : '0);
        div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
        acc_step  = acc_q;
        if (state_q == MULT) begin
            acc_step = {1'b0, mult_sum, acc_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            if (div_shift[2*WIDTH:WIDTH] >= opnd_q)
                acc_step = {div_shift[2*WIDTH:WIDTH] - opnd_q, div_shift[WIDTH-1:1], 1'b1};
            else
                acc_step = div_shift;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            is_mult_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start_mult || bus.start_div) begin
                        cnt_q     <= '0;
                        sign_a_q  <= bus.op_a[WIDTH-1];
                        sign_b_q  <= bus.op_b[WIDTH-1];
                        is_mult_q <= bus.start_mult;
                        dz_q      <= !bus.start_mult && (bus.op_b == '0);
                        opnd_q    <= bus.start_mult ? mag_a : mag_b;
                        acc_q     <= {{WIDTH{1'b0}}, (bus.start_mult ? mag_b : mag_a)};
                    end
                end
                MULT, DIV: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = (state_q == DONE) && dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: signed mult/div vectors, div-by-zero, ignored start, mid-op reset.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Latency counts rising edges from the start edge up to the one that opens the done cycle.
    task automatic run_op(input string tag, input bit mult, input bit both,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit exp_dz, input int exp_lat, input int poke_at);
        int lat;
        bit seen;
        @(negedge clock);
        bus.start_mult = mult | both;
        bus.start_div  = !mult | both;
        bus.op_a       = a;
        bus.op_b       = b;
        @(posedge clock);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = ~a;
        bus.op_b       = 32'h5;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (lat == 1) check({tag, " busy"}, 64'(bus.busy), 64'd1);
            bus.start_div = (poke_at != 0 && lat == poke_at);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            lat++;
        end
        bus.start_div = 1'b0;
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        check({tag, " hi"}, 64'(bus.hi_out), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo_out), 64'(exp_lo));
        @(negedge clock);
        check({tag, " done cleared"}, 64'(bus.done), 64'd0);
        check({tag, " idle after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int dones;
        reset          = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        check("reset hi", 64'(bus.hi_out), 64'd0);
        check("reset lo", 64'(bus.lo_out), 64'd0);
        reset = 1'b0;

        run_op("mul 7*-3",     1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, 0);
        run_op("mul min*min",  1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 33, 0);
        run_op("mul -1*-1",    1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 33, 0);
        run_op("div 7/-2",     0, 0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 33, 0);
        run_op("div -7/2",     0, 0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, 0);
        run_op("div 100/7",    0, 0, 32'd100,      32'd7,        32'd2,        32'd14,       0, 33, 0);
        run_op("div -100/7",   0, 0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 0, 33, 0);
        run_op("div ovf",      0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 33, 0);
        run_op("both 5*6",     0, 1, 32'd5,        32'd6,        32'h00000000, 32'd30,       0, 33, 0);
        run_op("preload 2*3",  1, 0, 32'd2,        32'd3,        32'h00000000, 32'd6,        0, 33, 0);
        run_op("div 5/0",      0, 0, 32'd5,        32'd0,        32'h00000000, 32'd6,        1, 1,  0);
        run_op("mul poke div", 1, 0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0, 33, 5);

        // Reset lands on the tenth edge of a running mult.
        @(negedge clock);
        bus.start_mult = 1'b1;
        bus.op_a       = 32'd3;
        bus.op_b       = 32'd9;
        @(posedge clock);
        #1;
        bus.start_mult = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset done", 64'(bus.done), 64'd0);
        check("mid reset hi", 64'(bus.hi_out), 64'd0);
        check("mid reset lo", 64'(bus.lo_out), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check("no done after reset", 64'(dones), 64'd0);
        run_op("mul 3*4", 1, 0, 32'd3, 32'd4, 32'h00000000, 32'd12, 0, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
